// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and MEM-stage data access.
// Data has priority, each transaction owns the bus until acked, and flushed fetches are dropped silently.
module mem_port_arbiter #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_if_flush,
  output logic                o_if_valid,
  output logic [XLEN-1:0]     o_if_rdata,
  output logic                o_if_stall,
  input  logic                i_d_req,
  input  logic                i_d_we,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [XLEN-1:0]     i_d_wdata,
  input  logic [XLEN/8-1:0]   i_d_be,
  output logic                o_d_valid,
  output logic [XLEN-1:0]     o_d_rdata,
  output logic                o_d_stall,
  output logic                o_bus_req,
  output logic                o_bus_we,
  output logic [ADDR_W-1:0]   o_bus_addr,
  output logic [XLEN-1:0]     o_bus_wdata,
  output logic [XLEN/8-1:0]   o_bus_be,
  input  logic                i_bus_ack,
  input  logic [XLEN-1:0]     i_bus_rdata
);

  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2,
    S_DROP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [XLEN-1:0]     bus_wdata_q, bus_wdata_d;
  logic [BE_W-1:0]     bus_be_q, bus_be_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q, d_valid_d;
  logic [XLEN-1:0]     if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]     d_rdata_q, d_rdata_d;

  // A flush in the response cycle kills the fetch pulse.
  assign o_if_valid  = if_valid_q && !i_if_flush;
  assign o_d_valid   = d_valid_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_if_stall  = i_if_req && !o_if_valid;
  assign o_d_stall   = i_d_req && !o_d_valid;
  assign o_bus_req   = bus_req_q;
  assign o_bus_we    = bus_we_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_wdata = bus_wdata_q;
  assign o_bus_be    = bus_be_q;

  // Grant, completion and drop decisions.
  always_comb begin
    state_d     = state_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        // Requesters pulsing valid this cycle are skipped so a finished request is not reissued.
        if (i_d_req && !o_d_valid) begin
          state_d     = S_DATA;
          bus_we_d    = i_d_we;
          bus_addr_d  = i_d_addr;
          bus_wdata_d = i_d_wdata;
          bus_be_d    = i_d_be;
        end else if (i_if_req && !o_if_valid && !i_if_flush) begin
          state_d    = S_FETCH;
          bus_we_d   = 1'b0;
          bus_addr_d = i_if_addr;
          bus_be_d   = {BE_W{1'b1}};
        end
      end
      S_FETCH: begin
        if (i_bus_ack) begin
          state_d = S_IDLE;
          if (!i_if_flush) begin
            if_valid_d = 1'b1;
            if_rdata_d = i_bus_rdata;
          end
        end else if (i_if_flush) begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (i_bus_ack) begin
          state_d   = S_IDLE;
          d_valid_d = 1'b1;
          if (!bus_we_q) begin
            d_rdata_d = i_bus_rdata;
          end
        end
      end
      S_DROP: begin
        if (i_bus_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    bus_req_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal expectations,
// then random requesters and bus slave checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = XLEN / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, if_flush, if_valid, if_stall;
  logic [ADDR_W-1:0] if_addr;
  logic [XLEN-1:0]   if_rdata;
  logic              d_req, d_we, d_valid, d_stall;
  logic [ADDR_W-1:0] d_addr;
  logic [XLEN-1:0]   d_wdata, d_rdata;
  logic [BE_W-1:0]   d_be;
  logic              bus_req, bus_we, bus_ack;
  logic [ADDR_W-1:0] bus_addr;
  logic [XLEN-1:0]   bus_wdata, bus_rdata;
  logic [BE_W-1:0]   bus_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_valid(if_valid), .o_if_rdata(if_rdata), .o_if_stall(if_stall),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_be(d_be),
    .o_d_valid(d_valid), .o_d_rdata(d_rdata), .o_d_stall(d_stall),
    .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
    .o_bus_wdata(bus_wdata), .o_bus_be(bus_be),
    .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the transaction currently owning the bus plus pending responses.
  bit        m_busy, m_is_data, m_drop, m_we;
  bit [31:0] m_addr, m_wdata;
  bit [3:0]  m_be;
  bit        m_ifv, m_dv;
  bit [31:0] m_if_rdata, m_d_rdata;
  bit        e_ifv, e_dv;

  task automatic model_reset();
    m_busy = 1'b0; m_is_data = 1'b0; m_drop = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_be = '0;
    m_ifv = 1'b0; m_dv = 1'b0; m_if_rdata = '0; m_d_rdata = '0;
    e_ifv = 1'b0; e_dv = 1'b0;
  endtask

  task automatic drive_zero();
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    bus_ack = 1'b0; bus_rdata = '0;
  endtask

  // One clock cycle: drive inputs, compare every output to the model, advance the model.
  task automatic step(input bit fr, input bit [31:0] fa, input bit fl,
                      input bit dr, input bit dw, input bit [31:0] da, input bit [31:0] dwd,
                      input bit [3:0] dbe, input bit ack, input bit [31:0] rd);
    @(negedge clk);
    if_req = fr; if_addr = fa; if_flush = fl;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; d_be = dbe;
    bus_ack = ack; bus_rdata = rd;
    #1;
    e_ifv = m_ifv && !fl;
    e_dv  = m_dv;
    chk("bus_req",  32'(bus_req),  32'(m_busy));
    chk("if_valid", 32'(if_valid), 32'(e_ifv));
    chk("d_valid",  32'(d_valid),  32'(e_dv));
    chk("if_stall", 32'(if_stall), 32'(fr && !e_ifv));
    chk("d_stall",  32'(d_stall),  32'(dr && !e_dv));
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_rdata",  d_rdata,  m_d_rdata);
    if (m_busy) begin
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_we",   32'(bus_we), 32'(m_we));
      chk("bus_be",   32'(bus_be), 32'(m_be));
      if (m_is_data) chk("bus_wdata", bus_wdata, m_wdata);
    end
    m_ifv = 1'b0;
    m_dv  = 1'b0;
    if (m_busy) begin
      if (ack) begin
        m_busy = 1'b0;
        if (m_is_data) begin
          m_dv = 1'b1;
          if (!m_we) m_d_rdata = rd;
        end else if (!m_drop && !fl) begin
          m_ifv = 1'b1;
          m_if_rdata = rd;
        end
      end else if (!m_is_data && fl) begin
        m_drop = 1'b1;
      end
    end else if (dr && !e_dv) begin
      m_busy = 1'b1; m_is_data = 1'b1; m_drop = 1'b0;
      m_we = dw; m_addr = da; m_wdata = dwd; m_be = dbe;
    end else if (fr && !e_ifv && !fl) begin
      m_busy = 1'b1; m_is_data = 1'b0; m_drop = 1'b0;
      m_we = 1'b0; m_addr = fa; m_be = 4'hF;
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask

  task automatic fstep(input bit fr, input bit [31:0] fa, input bit fl, input bit ack, input bit [31:0] rd);
    step(fr, fa, fl, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ack, rd);
  endtask

  bit        r_if_want, r_d_want, r_we, last_flush, flush, ack;
  bit [31:0] r_if_addr, r_daddr, r_wdata;
  bit [3:0]  r_be;

  initial begin
    rst_n = 1'b0;
    drive_zero();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Single fetch, ack at cycle 3.
    fstep(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    chk("t1_c0_bus_req", 32'(bus_req), 32'd0);
    chk("t1_c0_if_stall", 32'(if_stall), 32'd1);
    fstep(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    chk("t1_c1_bus_req", 32'(bus_req), 32'd1);
    chk("t1_c1_bus_addr", bus_addr, 32'h100);
    chk("t1_c1_bus_be", 32'(bus_be), 32'hF);
    fstep(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    fstep(1'b1, 32'h100, 1'b0, 1'b1, 32'h00500093);
    chk("t1_c3_bus_req", 32'(bus_req), 32'd1);
    fstep(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    chk("t1_c4_if_valid", 32'(if_valid), 32'd1);
    chk("t1_c4_if_rdata", if_rdata, 32'h00500093);
    chk("t1_c4_if_stall", 32'(if_stall), 32'd0);
    idle();
    chk("t1_c5_bus_req", 32'(bus_req), 32'd0);

    // Simultaneous fetch and load: data first, fetch granted on the data valid cycle.
    step(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0, 32'h0);
    step(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b1, 32'h11223344);
    chk("t2_c1_bus_addr", bus_addr, 32'h2000);
    chk("t2_c1_bus_we", 32'(bus_we), 32'd0);
    step(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0, 32'h0);
    chk("t2_c2_d_valid", 32'(d_valid), 32'd1);
    chk("t2_c2_d_rdata", d_rdata, 32'h11223344);
    fstep(1'b1, 32'h104, 1'b0, 1'b1, 32'h00000013);
    chk("t2_c3_bus_addr", bus_addr, 32'h104);
    chk("t2_c3_d_valid", 32'(d_valid), 32'd0);
    fstep(1'b1, 32'h104, 1'b0, 1'b0, 32'h0);
    chk("t2_c4_if_valid", 32'(if_valid), 32'd1);
    idle();

    // Store: fields on the bus, load data register untouched.
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'b0011, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'b0011, 1'b1, 32'hCAFEF00D);
    chk("t3_bus_we", 32'(bus_we), 32'd1);
    chk("t3_bus_wdata", bus_wdata, 32'hDEADBEEF);
    chk("t3_bus_be", 32'(bus_be), 32'h3);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'b0011, 1'b0, 32'h0);
    chk("t3_d_valid", 32'(d_valid), 32'd1);
    chk("t3_d_rdata", d_rdata, 32'h11223344);
    idle();

    // Flush mid-fetch: drop, then redirected fetch granted after the stale ack.
    fstep(1'b1, 32'h180, 1'b0, 1'b0, 32'h0);
    fstep(1'b1, 32'h180, 1'b0, 1'b0, 32'h0);
    fstep(1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
    fstep(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    chk("t4_drop_bus_req", 32'(bus_req), 32'd1);
    chk("t4_drop_bus_addr", bus_addr, 32'h180);
    fstep(1'b1, 32'h200, 1'b0, 1'b1, 32'hBAD0BAD0);
    fstep(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    chk("t4_c5_if_valid", 32'(if_valid), 32'd0);
    chk("t4_c5_bus_req", 32'(bus_req), 32'd0);
    fstep(1'b1, 32'h200, 1'b0, 1'b1, 32'hAAAA0001);
    chk("t4_c6_bus_addr", bus_addr, 32'h200);
    fstep(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    chk("t4_c7_if_rdata", if_rdata, 32'hAAAA0001);
    idle();

    // Flush coincident with ack, then flush in the response cycle.
    fstep(1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    fstep(1'b1, 32'h300, 1'b1, 1'b1, 32'h77777777);
    fstep(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t5a_if_valid", 32'(if_valid), 32'd0);
    chk("t5a_if_rdata", if_rdata, 32'hAAAA0001);
    fstep(1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
    fstep(1'b1, 32'h400, 1'b0, 1'b1, 32'h12345678);
    fstep(1'b1, 32'h404, 1'b1, 1'b0, 32'h0);
    chk("t5b_if_valid", 32'(if_valid), 32'd0);
    chk("t5b_bus_req", 32'(bus_req), 32'd0);
    idle();
    idle();

    // Reset while a load is in flight, then reissue.
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1'b0, 32'h0);
    chk("t6_pre_bus_req", 32'(bus_req), 32'd1);
    #1;
    drive_zero();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_bus_req", 32'(bus_req), 32'd0);
    chk("t6_rst_bus_addr", bus_addr, 32'd0);
    chk("t6_rst_bus_be", 32'(bus_be), 32'd0);
    chk("t6_rst_if_rdata", if_rdata, 32'd0);
    chk("t6_rst_d_rdata", d_rdata, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1'b0, 32'h0);
    chk("t6_c0_bus_req", 32'(bus_req), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1'b1, 32'h00000055);
    chk("t6_c1_bus_addr", bus_addr, 32'h3000);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1'b0, 32'h0);
    chk("t6_c2_d_rdata", d_rdata, 32'h00000055);
    idle();

    // Random requesters, flushes and slave acks.
    r_if_want = 1'b0; r_d_want = 1'b0; last_flush = 1'b0;
    r_if_addr = '0; r_daddr = '0; r_wdata = '0; r_we = 1'b0; r_be = '0;
    for (int n = 0; n < 3000; n++) begin
      if (e_ifv || last_flush) begin
        r_if_want = 1'($urandom_range(0, 1));
        r_if_addr = $urandom & 32'hFFFF_FFFC;
      end else if (!r_if_want) begin
        r_if_want = ($urandom_range(0, 3) == 0);
        r_if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (e_dv || !r_d_want) begin
        r_d_want = e_dv ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
        r_we     = 1'($urandom_range(0, 1));
        r_daddr  = $urandom;
        r_wdata  = $urandom;
        r_be     = 4'($urandom);
      end
      flush = ($urandom_range(0, 9) == 0);
      ack   = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      step(r_if_want, r_if_addr, flush, r_d_want, r_we, r_daddr, r_wdata, r_be, ack, $urandom);
      last_flush = flush;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
